// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc (package)
// Description : Shared Fibre Channel port definitions: primitive and port
//               state enums, default timeout constants, primitive
//               classification and per-state transmit primitive decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fc;

    typedef enum logic [2:0] {
        PRIM_NONE = 3'd0,
        PRIM_IDLE = 3'd1,
        PRIM_NOS  = 3'd2,
        PRIM_OLS  = 3'd3,
        PRIM_LR   = 3'd4,
        PRIM_LRR  = 3'd5
    } primitives_t;

    typedef enum logic [2:0] {
        AC  = 3'd0,
        LR1 = 3'd1,
        LR2 = 3'd2,
        LR3 = 3'd3,
        LF1 = 3'd4,
        LF2 = 3'd5,
        OL1 = 3'd6,
        OL2 = 3'd7
    } port_state_t;

    // 100 ms and 10 us at the 212.5 MHz recovered clock
    localparam int unsigned c_rttov_cycles_default = 21250000;
    localparam int unsigned c_los_cycles_default   = 2125;

    // Ordered sets, big-endian, K28.5 (0xBC) in the first byte
    localparam logic [31:0] c_os_idle = 32'hBC95_B5B5; // K28.5 D21.4 D21.5 D21.5
    localparam logic [31:0] c_os_nos  = 32'hBC55_BF45; // K28.5 D21.2 D31.5 D5.2
    localparam logic [31:0] c_os_ols  = 32'hBC35_8A55; // K28.5 D21.1 D10.4 D21.2
    localparam logic [31:0] c_os_lr   = 32'hBC49_BF49; // K28.5 D9.2  D31.5 D9.2
    localparam logic [31:0] c_os_lrr  = 32'hBC35_BF49; // K28.5 D21.1 D31.5 D9.2

    function automatic primitives_t map_primitive(input logic [31:0] word);
        primitives_t p;
        case (word)
            c_os_idle: p = PRIM_IDLE;
            c_os_nos:  p = PRIM_NOS;
            c_os_ols:  p = PRIM_OLS;
            c_os_lr:   p = PRIM_LR;
            c_os_lrr:  p = PRIM_LRR;
            default:   p = PRIM_NONE;
        endcase
        return p;
    endfunction

    function automatic primitives_t tx_prim_for_state(input port_state_t s);
        primitives_t p;
        case (s)
            AC:      p = PRIM_IDLE;
            LR1:     p = PRIM_LR;
            LR2:     p = PRIM_LRR;
            LR3:     p = PRIM_IDLE;
            LF1:     p = PRIM_OLS;
            LF2:     p = PRIM_NOS;
            OL1:     p = PRIM_OLS;
            OL2:     p = PRIM_LR;
            default: p = PRIM_NOS;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_port_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_port_fsm_if
// Description : Port state machine bundle. Carries the transceiver rx word
//               stream and host requests into the FSM, and the transmit
//               primitive / state / status back out.
//               master : rx stream + host side (drives inputs)
//               slave  : fc_port_fsm
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_port_fsm_if;
    import fc::*;

    logic [35:0] avrx_data;      // {datak[3:0], data[31:0]}
    logic        avrx_valid;
    logic        req_link_reset;
    logic        req_offline;
    primitives_t tx_prim;
    port_state_t port_state;
    logic        link_up;
    logic        rttov_expired;

    modport master (
        output avrx_data, avrx_valid, req_link_reset, req_offline,
        input  tx_prim, port_state, link_up, rttov_expired
    );

    modport slave (
        input  avrx_data, avrx_valid, req_link_reset, req_offline,
        output tx_prim, port_state, link_up, rttov_expired
    );

endinterface
`default_nettype wire

// File: rtl/fc_prim_seq_detect.sv
`default_nettype none
// ============================================================================
// Module      : fc_prim_seq_detect
// Description : Registers the rx word, classifies it as a primitive and
//               flags the third consecutive identical primitive.
// Ports       : i_clk, i_rst_n      - clock, async active-low reset
//               i_data, i_valid     - rx word {datak, data} and valid
//               o_recognized        - one-cycle strobe, 3rd identical word
//               o_prim              - primitive of the registered word
// Revision    : 1.0 - initial release
// ============================================================================
module fc_prim_seq_detect
    import fc::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [35:0] i_data,
    input  logic        i_valid,
    output logic        o_recognized,
    output primitives_t o_prim
);

    logic [35:0] r_data;
    logic        r_valid;
    primitives_t r_run_prim;
    logic [1:0]  r_count;      // saturates at 3
    primitives_t w_prim;
    logic        w_recog;

    // Only a K28.5-led word on a valid cycle can be a primitive; everything
    // else classifies as PRIM_NONE and breaks the run.
    assign w_prim  = (r_valid && (r_data[35:32] == 4'b1000)) ? map_primitive(r_data[31:0])
                                                               : PRIM_NONE;
    // Fires only on the 2->3 step, so a 4th+ identical word is silent.
    assign w_recog = (w_prim != PRIM_NONE) && (w_prim == r_run_prim) && (r_count == 2'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_run_prim <= PRIM_NONE;
            r_count    <= 2'd0;
        end else begin
            r_data  <= i_data;
            r_valid <= i_valid;
            if (w_prim == PRIM_NONE) begin
                r_run_prim <= PRIM_NONE;
                r_count    <= 2'd0;
            end else if (w_prim == r_run_prim) begin
                if (r_count != 2'd3) begin
                    r_count <= r_count + 2'd1;
                end
            end else begin
                r_run_prim <= w_prim;
                r_count    <= 2'd1;
            end
        end
    end

    assign o_recognized = w_recog;
    assign o_prim       = w_prim;

endmodule
`default_nettype wire

// File: rtl/fc_port_fsm.sv
`default_nettype none
// ============================================================================
// Module      : fc_port_fsm
// Description : Fibre Channel port state machine (AC/LR/LF/OL) with primitive
//               sequence recognition, loss-of-sync and R_T_TOV supervision.
// Ports       : rx_clk   - transceiver rx clock (sole clock)
//               reset_n  - async active-low reset, deassertion synchronized
//               bus      - fc_port_fsm_if.slave: rx words, host requests,
//                          tx_prim / port_state / link_up / rttov_expired
// Revision    : 1.0 - initial release
// ============================================================================
module fc_port_fsm
    import fc::*;
#(
    parameter int unsigned RTTOV_CYCLES = c_rttov_cycles_default,
    parameter int unsigned LOS_CYCLES   = c_los_cycles_default
) (
    input  logic         rx_clk,
    input  logic         reset_n,
    fc_port_fsm_if.slave bus
);

    localparam logic [31:0] c_rttov_limit = 32'(RTTOV_CYCLES - 1);
    localparam logic [31:0] c_los_limit   = 32'(LOS_CYCLES - 1);

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    port_state_t r_state;
    primitives_t r_tx_prim;
    logic        r_link_up;
    logic        r_rttov_expired;
    logic [31:0] r_tov_cnt;
    logic [31:0] r_los_cnt;

    logic        w_recog;
    primitives_t w_prim;
    logic        w_timed;
    logic        w_los_hit;
    logic        w_tov_hit;
    logic        w_tov_take;
    port_state_t w_recog_state;
    port_state_t w_next_state;

    // Assert passes straight through; release is retimed by two flops.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    fc_prim_seq_detect u_detect (
        .i_clk        (rx_clk),
        .i_rst_n      (w_rst_n),
        .i_data       (bus.avrx_data),
        .i_valid      (bus.avrx_valid),
        .o_recognized (w_recog),
        .o_prim       (w_prim)
    );

    assign w_timed   = (r_state == LR1) || (r_state == LR2) ||
                       (r_state == LR3) || (r_state == OL2);
    // LOS uses the raw valid so it is judged in the same cycle the
    // recognition strobe (from the registered word) arrives.
    assign w_los_hit = !bus.avrx_valid && (r_los_cnt >= c_los_limit) && (r_state != OL1);
    assign w_tov_hit = w_timed && (r_tov_cnt >= c_rttov_limit);

    // Target state for a recognized primitive; equal to r_state when the
    // primitive has no meaning in the current state.
    always_comb begin
        w_recog_state = r_state;
        if (w_recog) begin
            case (r_state)
                AC, LR1: begin
                    case (w_prim)
                        PRIM_LR:  w_recog_state = LR2;
                        PRIM_LRR: w_recog_state = LR3;
                        PRIM_NOS: w_recog_state = LF1;
                        PRIM_OLS: w_recog_state = OL2;
                        default:  w_recog_state = r_state;
                    endcase
                end
                LR2: begin
                    case (w_prim)
                        PRIM_IDLE: w_recog_state = AC;
                        PRIM_LRR:  w_recog_state = LR3;
                        PRIM_NOS:  w_recog_state = LF1;
                        default:   w_recog_state = r_state;
                    endcase
                end
                LR3: begin
                    case (w_prim)
                        PRIM_IDLE: w_recog_state = AC;
                        PRIM_LR:   w_recog_state = LR2;
                        PRIM_NOS:  w_recog_state = LF1;
                        default:   w_recog_state = r_state;
                    endcase
                end
                LF1: begin
                    if (w_prim == PRIM_OLS) w_recog_state = OL2;
                end
                LF2: begin
                    case (w_prim)
                        PRIM_OLS: w_recog_state = OL2;
                        PRIM_LR:  w_recog_state = LR2;
                        default:  w_recog_state = r_state;
                    endcase
                end
                OL1: begin
                    // Host must release offline before the link can leave OL1
                    if (!bus.req_offline) begin
                        case (w_prim)
                            PRIM_OLS: w_recog_state = OL2;
                            PRIM_LR:  w_recog_state = LR2;
                            default:  w_recog_state = r_state;
                        endcase
                    end
                end
                OL2: begin
                    case (w_prim)
                        PRIM_LRR: w_recog_state = LR3;
                        PRIM_LR:  w_recog_state = LR2;
                        PRIM_NOS: w_recog_state = LF1;
                        default:  w_recog_state = r_state;
                    endcase
                end
                default: w_recog_state = r_state;
            endcase
        end
    end

    // Event priority: LOS > R_T_TOV > primitive > offline > link reset.
    // req_link_reset only counts in AC and is otherwise dropped.
    always_comb begin
        w_next_state = r_state;
        w_tov_take   = 1'b0;
        if (w_los_hit) begin
            w_next_state = LF2;
        end else if (w_tov_hit) begin
            w_next_state = LF2;
            w_tov_take   = 1'b1;
        end else if (w_recog_state != r_state) begin
            w_next_state = w_recog_state;
        end else if ((r_state == AC) && bus.req_offline) begin
            w_next_state = OL1;
        end else if ((r_state == AC) && bus.req_link_reset) begin
            w_next_state = LR1;
        end
    end

    always_ff @(posedge rx_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state         <= LF2;
            r_tx_prim       <= PRIM_NOS;
            r_link_up       <= 1'b0;
            r_rttov_expired <= 1'b0;
            r_tov_cnt       <= 32'd0;
            r_los_cnt       <= 32'd0;
        end else begin
            r_state         <= w_next_state;
            // Outputs decoded from the next state so they align with port_state
            r_tx_prim       <= tx_prim_for_state(w_next_state);
            r_link_up       <= (w_next_state == AC);
            r_rttov_expired <= w_tov_take;

            if (bus.avrx_valid) begin
                r_los_cnt <= 32'd0;
            end else if (r_los_cnt != 32'hFFFF_FFFF) begin
                r_los_cnt <= r_los_cnt + 32'd1;
            end

            if ((w_next_state != r_state) || !w_timed) begin
                r_tov_cnt <= 32'd0;
            end else if (r_tov_cnt != 32'hFFFF_FFFF) begin
                r_tov_cnt <= r_tov_cnt + 32'd1;
            end
        end
    end

    assign bus.port_state    = r_state;
    assign bus.tx_prim       = r_tx_prim;
    assign bus.link_up       = r_link_up;
    assign bus.rttov_expired = r_rttov_expired;

endmodule
`default_nettype wire

// File: tb/tb_fc_port_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_port_fsm
// Description : Directed self-checking bench for fc_port_fsm. u_dut uses a
//               short R_T_TOV and LOS window; u_dut_los1 shares the stimulus
//               with a one-cycle LOS window so loss-of-sync can coincide
//               with a primitive recognition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_port_fsm;
    import fc::*;

    localparam int unsigned RTTOV = 100;
    localparam int unsigned LOS   = 16;

    localparam logic [35:0] W_IDLE = {4'b1000, 32'hBC95_B5B5};
    localparam logic [35:0] W_NOS  = {4'b1000, 32'hBC55_BF45};
    localparam logic [35:0] W_OLS  = {4'b1000, 32'hBC35_8A55};
    localparam logic [35:0] W_LR   = {4'b1000, 32'hBC49_BF49};
    localparam logic [35:0] W_LRR  = {4'b1000, 32'hBC35_BF49};
    localparam logic [35:0] W_FILL = {4'b0000, 32'h1234_5678};

    logic        rx_clk = 1'b0;
    logic        reset_n;
    logic [35:0] avrx_data;
    logic        avrx_valid;
    logic        req_link_reset;
    logic        req_offline;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 rx_clk = ~rx_clk;

    fc_port_fsm_if bus_a ();
    fc_port_fsm_if bus_b ();

    assign bus_a.avrx_data      = avrx_data;
    assign bus_a.avrx_valid     = avrx_valid;
    assign bus_a.req_link_reset = req_link_reset;
    assign bus_a.req_offline    = req_offline;
    assign bus_b.avrx_data      = avrx_data;
    assign bus_b.avrx_valid     = avrx_valid;
    assign bus_b.req_link_reset = req_link_reset;
    assign bus_b.req_offline    = req_offline;

    fc_port_fsm #(.RTTOV_CYCLES(RTTOV), .LOS_CYCLES(LOS)) u_dut (
        .rx_clk  (rx_clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    fc_port_fsm #(.RTTOV_CYCLES(RTTOV), .LOS_CYCLES(1)) u_dut_los1 (
        .rx_clk  (rx_clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic send_word(input logic [35:0] w);
        avrx_data  = w;
        avrx_valid = 1'b1;
        tick();
    endtask

    task automatic send3(input logic [35:0] w);
        for (int i = 0; i < 3; i++) send_word(w);
    endtask

    task automatic chk_a(input string tag, input port_state_t s);
        check(tag, 32'(bus_a.port_state), 32'(s));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lf2_at;
        int pulse_at;
        int pulses;

        reset_n        = 1'b0;
        avrx_data      = W_FILL;
        avrx_valid     = 1'b1;
        req_link_reset = 1'b0;
        req_offline    = 1'b0;

        // Reset values
        repeat (3) tick();
        chk_a("rst_state", LF2);
        check("rst_tx", 32'(bus_a.tx_prim), 32'(PRIM_NOS));
        check("rst_link", 32'(bus_a.link_up), 32'd0);
        check("rst_tov", 32'(bus_a.rttov_expired), 32'd0);
        reset_n = 1'b1;
        repeat (4) tick();
        chk_a("post_rst", LF2);

        // NOS in LF2 does nothing; OLS -> OL2; LRR -> LR3; IDLE -> AC
        send3(W_NOS);
        send_word(W_FILL);
        chk_a("nos_lf2", LF2);
        send3(W_OLS);
        chk_a("ols_n1", LF2);
        send_word(W_FILL);
        chk_a("ols_ol2", OL2);
        check("ol2_tx", 32'(bus_a.tx_prim), 32'(PRIM_LR));
        send3(W_LRR);
        send_word(W_FILL);
        chk_a("lrr_lr3", LR3);
        send3(W_IDLE);
        check("idle_n1_link", 32'(bus_a.link_up), 32'd0);
        send_word(W_FILL);
        chk_a("idle_ac", AC);
        check("ac_link", 32'(bus_a.link_up), 32'd1);
        check("ac_tx", 32'(bus_a.tx_prim), 32'(PRIM_IDLE));

        // Broken LR runs do not trigger; a real third LR does
        send_word(W_LR);
        send_word(W_LR);
        send_word(W_IDLE);
        send_word(W_LR);
        send_word(W_LR);
        send_word(W_LR);
        chk_a("lr_broken", AC);
        send_word(W_FILL);
        chk_a("lr_lr2", LR2);
        check("lr2_tx", 32'(bus_a.tx_prim), 32'(PRIM_LRR));
        check("lr2_link", 32'(bus_a.link_up), 32'd0);
        send3(W_IDLE);
        send_word(W_FILL);
        chk_a("back_ac1", AC);

        // Offline: OLS ignored while req_offline held, LR accepted after
        req_offline = 1'b1;
        tick();
        chk_a("off_ol1", OL1);
        check("ol1_tx", 32'(bus_a.tx_prim), 32'(PRIM_OLS));
        send3(W_OLS);
        send_word(W_FILL);
        chk_a("off_hold", OL1);
        req_offline = 1'b0;
        send3(W_LR);
        send_word(W_FILL);
        chk_a("off_lr2", LR2);
        send3(W_IDLE);
        send_word(W_FILL);
        chk_a("back_ac2", AC);

        // Loss of sync boundary
        avrx_valid = 1'b0;
        repeat (LOS - 1) tick();
        avrx_valid = 1'b1;
        repeat (3) tick();
        chk_a("los_short", AC);
        avrx_valid = 1'b0;
        repeat (LOS - 1) tick();
        chk_a("los_pre", AC);
        tick();
        chk_a("los_lf2", LF2);
        check("los_tx", 32'(bus_a.tx_prim), 32'(PRIM_NOS));
        avrx_valid = 1'b1;
        send3(W_LR);
        send_word(W_FILL);
        chk_a("lf2_lr2", LR2);
        send3(W_IDLE);
        send_word(W_FILL);
        chk_a("back_ac3", AC);

        // R_T_TOV from LR1
        req_link_reset = 1'b1;
        tick();
        req_link_reset = 1'b0;
        chk_a("lrst_lr1", LR1);
        check("lr1_tx", 32'(bus_a.tx_prim), 32'(PRIM_LR));
        lf2_at = 0;
        pulse_at = 0;
        pulses = 0;
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (bus_a.rttov_expired) begin
                pulses++;
                pulse_at = i;
            end
            if ((lf2_at == 0) && (bus_a.port_state == LF2)) lf2_at = i;
        end
        check("tov_lf2_cycle", 32'(lf2_at), 32'd100);
        check("tov_pulse_cycle", 32'(pulse_at), 32'd100);
        check("tov_pulses", 32'(pulses), 32'd1);

        // req_link_reset outside AC is dropped
        req_link_reset = 1'b1;
        tick();
        req_link_reset = 1'b0;
        repeat (2) tick();
        chk_a("lrst_ignored", LF2);

        // LOS coincides with the third IDLE in LR2
        do_reset();
        send3(W_LR);
        send_word(W_FILL);
        chk_a("co_a_lr2", LR2);
        check("co_b_lr2", 32'(bus_b.port_state), 32'(LR2));
        send3(W_IDLE);
        avrx_valid = 1'b0;
        tick();
        check("co_b_lf2", 32'(bus_b.port_state), 32'(LF2));
        check("co_b_link", 32'(bus_b.link_up), 32'd0);
        chk_a("co_a_ac", AC);
        avrx_valid = 1'b1;
        avrx_data  = W_FILL;
        tick();

        // Asynchronous reset mid-LR3
        send3(W_LRR);
        send_word(W_FILL);
        chk_a("pre_rst_lr3", LR3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("arst_state", LF2);
        check("arst_tx", 32'(bus_a.tx_prim), 32'(PRIM_NOS));
        check("arst_link", 32'(bus_a.link_up), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk_a("arst_release", LF2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
